// File: rtl/axi_sram_slave.sv
// ============================================================================
// Module  : axi_sram_slave
// Brief   : AXI3 single-port word-memory responder with independent read/write FSMs
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_sram_slave #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [31:0] mem [2**ADDR_W];

    // FIXED keeps the address; INCR, WRAP and the reserved code all increment
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] br);
        return (br == 2'b00) ? a : a + (32'd1 << sz);
    endfunction

    // ---------------- read channel ----------------
    rstate_t     rstate_q;
    logic [3:0]  rid_q, rlat_q;
    logic [31:0] raddr_q, raddr_d, rdata_q;
    logic [7:0]  rlen_q, rbeat_q;
    logic [2:0]  rsize_q;
    logic [1:0]  rburst_q;
    logic        arready_q, rvalid_q, rlast_q;

    assign raddr_d = next_addr(raddr_q, rsize_q, rburst_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            raddr_q   <= 32'd0;
            rlen_q    <= 8'd0;
            rbeat_q   <= 8'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'd0;
            rlat_q    <= 4'd0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arvalid && arready_q) begin
                        rid_q     <= arid;
                        raddr_q   <= araddr;
                        rlen_q    <= arlen;
                        rsize_q   <= arsize;
                        rburst_q  <= arburst;
                        rbeat_q   <= 8'd0;
                        rlat_q    <= 4'd0;
                        arready_q <= 1'b0;
                        if (RD_LAT == 0) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= mem[araddr[ADDR_W+1:2]];
                            rlast_q  <= (arlen == 8'd0);
                            rstate_q <= R_DATA;
                        end else begin
                            rstate_q <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rlat_q == LAT_LAST) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= mem[raddr_q[ADDR_W+1:2]];
                        rlast_q  <= (rlen_q == 8'd0);
                        rstate_q <= R_DATA;
                    end else begin
                        rlat_q <= rlat_q + 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            // memory read sees pre-write contents on a same-cycle write
                            raddr_q <= raddr_d;
                            rdata_q <= mem[raddr_d[ADDR_W+1:2]];
                            rbeat_q <= rbeat_q + 8'd1;
                            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wstate_t     wstate_q;
    logic [3:0]  awid_q, bid_q;
    logic [31:0] waddr_q;
    logic [7:0]  wlen_q, wbeat_q;
    logic [2:0]  wsize_q;
    logic [1:0]  wburst_q, bresp_q;
    logic        awready_q, wready_q, bvalid_q, werr_q;
    logic        w_fire, w_final, w_beat_err;

    assign w_fire     = wvalid && wready_q;
    assign w_final    = (wbeat_q == wlen_q);
    assign w_beat_err = (wlast != w_final) || (wid != awid_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= 4'd0;
            awid_q    <= 4'd0;
            waddr_q   <= 32'd0;
            wlen_q    <= 8'd0;
            wbeat_q   <= 8'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'd0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (awvalid && awready_q) begin
                        awid_q    <= awid;
                        waddr_q   <= awaddr;
                        wlen_q    <= awlen;
                        wsize_q   <= awsize;
                        wburst_q  <= awburst;
                        wbeat_q   <= 8'd0;
                        werr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr_q <= next_addr(waddr_q, wsize_q, wburst_q);
                        wbeat_q <= wbeat_q + 8'd1;
                        werr_q  <= werr_q | w_beat_err;
                        // the beat count, not wlast, terminates the burst
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= awid_q;
                            bresp_q  <= (werr_q || w_beat_err) ? 2'b10 : 2'b00;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // storage has no reset so contents survive an aresetn pulse
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr_q[ADDR_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot};

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = 2'b00;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
// ============================================================================
// Module  : tb_axi_sram_slave
// Brief   : directed self-checking bench for axi_sram_slave
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0, awid = '0, wid = '0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = 3'd2, awsize = 3'd2;
    logic [1:0]  arburst = 2'b01, awburst = 2'b01;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = 4'hF;
    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int total = 0;
    int bad   = 0;
    logic [31:0] d;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(16), .RD_LAT(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return arready;
            1:       return awready;
            2:       return wready;
            3:       return rvalid;
            default: return bvalid;
        endcase
    endfunction

    task automatic wait_for(input int w, input string tag);
        int n = 0;
        while (sel(w) !== 1'b1 && n < 100) begin
            step;
            n++;
        end
        chk(tag, 32'(sel(w)), 32'd1);
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        awaddr = a; awlen = l; awid = id; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wait_for(1, "awready");
        step;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] dt, input logic [3:0] s, input logic last,
                        input logic [3:0] id);
        wdata = dt; wstrb = s; wlast = last; wid = id; wvalid = 1'b1;
        wait_for(2, "wready");
        step;
        wvalid = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
        wait_for(4, {tag, "_bvalid"});
        chk({tag, "_bid"}, 32'(bid), 32'(id));
        chk({tag, "_bresp"}, 32'(bresp), 32'(resp));
        bready = 1'b1;
        step;
        bready = 1'b0;
    endtask

    task automatic write1(input string tag, input logic [31:0] a, input logic [31:0] dt,
                          input logic [3:0] s, input logic [3:0] id);
        do_aw(a, 8'd0, id);
        do_w(dt, s, 1'b1, id);
        do_b(tag, id, 2'b00);
    endtask

    task automatic rd1(input logic [31:0] a, output logic [31:0] dt);
        araddr = a; arlen = 8'd0; arid = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        wait_for(0, "arready");
        step;
        arvalid = 1'b0;
        wait_for(3, "rvalid");
        dt = rdata;
        rready = 1'b1;
        step;
        rready = 1'b0;
    endtask

    initial begin
        // T1: reset holds the channels idle even with arvalid asserted
        arvalid = 1'b1; araddr = 32'h100;
        step; step;
        chk("T1_arready", 32'(arready), 32'd1);
        chk("T1_awready", 32'(awready), 32'd1);
        chk("T1_rvalid", 32'(rvalid), 32'd0);
        chk("T1_wready", 32'(wready), 32'd0);
        chk("T1_bvalid", 32'(bvalid), 32'd0);
        chk("T1_rdata", rdata, 32'd0);
        arvalid = 1'b0;
        aresetn = 1'b1;
        step; step; step;
        chk("T1_no_capture", 32'(rvalid), 32'd0);

        // T2: preload words 0x40..0x4F with their index, then a 16-beat line fill
        do_aw(32'h100, 8'd15, 4'd3);
        for (int i = 0; i < 16; i++) do_w(32'h40 + 32'(i), 4'hF, (i == 15), 4'd3);
        do_b("T2_pre", 4'd3, 2'b00);
        araddr = 32'h100; arlen = 8'd15; arid = 4'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1; rready = 1'b1;
        chk("T2_arready", 32'(arready), 32'd1);
        step;
        arvalid = 1'b0;
        chk("T2_lat_rvalid", 32'(rvalid), 32'd0);
        chk("T2_arready_drop", 32'(arready), 32'd0);
        step;
        for (int i = 0; i < 16; i++) begin
            chk("T2_rvalid", 32'(rvalid), 32'd1);
            chk("T2_rdata", rdata, 32'h40 + 32'(i));
            chk("T2_rid", 32'(rid), 32'd3);
            chk("T2_rlast", 32'(rlast), 32'(i == 15));
            chk("T2_rresp", 32'(rresp), 32'd0);
            step;
        end
        rready = 1'b0;
        chk("T2_done_rvalid", 32'(rvalid), 32'd0);
        chk("T2_done_arready", 32'(arready), 32'd1);

        // T3: read backpressure keeps the beat stable
        araddr = 32'h104; arlen = 8'd0; arid = 4'd7; arvalid = 1'b1;
        step;
        arvalid = 1'b0;
        wait_for(3, "T3_rvalid_wait");
        for (int i = 0; i < 5; i++) begin
            chk("T3_hold_rvalid", 32'(rvalid), 32'd1);
            chk("T3_hold_rdata", rdata, 32'h41);
            chk("T3_hold_rlast", 32'(rlast), 32'd1);
            chk("T3_hold_rid", 32'(rid), 32'd7);
            step;
        end
        rready = 1'b1;
        step;
        rready = 1'b0;
        chk("T3_consumed", 32'(rvalid), 32'd0);
        chk("T3_arready", 32'(arready), 32'd1);

        // FIXED burst returns the same word every beat
        araddr = 32'h108; arlen = 8'd2; arburst = 2'b00; arvalid = 1'b1; rready = 1'b1;
        step;
        arvalid = 1'b0;
        wait_for(3, "FX_rvalid_wait");
        for (int i = 0; i < 3; i++) begin
            chk("FX_rdata", rdata, 32'h42);
            chk("FX_rlast", 32'(rlast), 32'(i == 2));
            step;
        end
        rready = 1'b0; arburst = 2'b01;
        chk("FX_done", 32'(rvalid), 32'd0);

        // T4: byte-lane write and held write response
        write1("T4_init", 32'h8, 32'h11223344, 4'hF, 4'd1);
        do_aw(32'h8, 8'd0, 4'd1);
        do_w(32'hAABBCCDD, 4'b0010, 1'b1, 4'd1);
        wait_for(4, "T4_bvalid_wait");
        for (int i = 0; i < 3; i++) begin
            chk("T4_hold_bvalid", 32'(bvalid), 32'd1);
            chk("T4_hold_bid", 32'(bid), 32'd1);
            chk("T4_hold_bresp", 32'(bresp), 32'd0);
            step;
        end
        bready = 1'b1;
        step;
        bready = 1'b0;
        chk("T4_bvalid_clr", 32'(bvalid), 32'd0);
        chk("T4_awready", 32'(awready), 32'd1);
        rd1(32'h8, d);
        chk("T4_readback", d, 32'h1122CC44);

        // T5: early wlast and late missing wlast give SLVERR but still write
        do_aw(32'h20, 8'd1, 4'd2);
        do_w(32'h1, 4'hF, 1'b1, 4'd2);
        do_w(32'h2, 4'hF, 1'b0, 4'd2);
        do_b("T5_err", 4'd2, 2'b10);
        rd1(32'h20, d);
        chk("T5_beat0", d, 32'h1);
        rd1(32'h24, d);
        chk("T5_beat1", d, 32'h2);
        write1("T5_clean", 32'h28, 32'h5, 4'hF, 4'd2);
        do_aw(32'h2C, 8'd0, 4'd4);
        do_w(32'h7, 4'hF, 1'b1, 4'd5);
        do_b("T5_wid", 4'd4, 2'b10);

        // T6: same-cycle AR/AW to one word; read sees the old contents
        write1("T6_init", 32'h30, 32'h12345678, 4'hF, 4'd0);
        araddr = 32'h30; arlen = 8'd0; arid = 4'd5; arvalid = 1'b1;
        awaddr = 32'h30; awlen = 8'd0; awid = 4'd6; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wlast = 1'b1; wid = 4'd6; wvalid = 1'b1;
        chk("T6_arready", 32'(arready), 32'd1);
        chk("T6_awready", 32'(awready), 32'd1);
        step;
        arvalid = 1'b0; awvalid = 1'b0;
        chk("T6_wready", 32'(wready), 32'd1);
        step;
        wvalid = 1'b0;
        chk("T6_rvalid", 32'(rvalid), 32'd1);
        chk("T6_old_data", rdata, 32'h12345678);
        chk("T6_rid", 32'(rid), 32'd5);
        rready = 1'b1;
        step;
        rready = 1'b0;
        do_b("T6_b", 4'd6, 2'b00);
        rd1(32'h30, d);
        chk("T6_new_data", d, 32'hDEADBEEF);

        // reset in the middle of a line fill
        araddr = 32'h100; arlen = 8'd15; arid = 4'd3; arvalid = 1'b1; rready = 1'b1;
        step;
        arvalid = 1'b0;
        step; step; step;
        chk("RST_mid_rvalid", 32'(rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("RST_rvalid", 32'(rvalid), 32'd0);
        chk("RST_arready", 32'(arready), 32'd1);
        chk("RST_rlast", 32'(rlast), 32'd0);
        step;
        aresetn = 1'b1;
        step;
        rready = 1'b0;
        chk("RST_idle", 32'(rvalid), 32'd0);
        rd1(32'h104, d);
        chk("RST_mem_kept", d, 32'h41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
